// File: rtl/four_bit_minmax_tracker.sv
// four_bit_minmax_tracker: windowed running max/min/rise tracker over a valid/ready sample stream.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid, in_data, in_ready    sample input handshake
//   out_valid, out_ready           result record handshake
//   out_max, out_min               largest / smallest sample in the window
//   out_max_cnt, out_min_cnt       occurrences of out_max / out_min
//   out_rise_cnt                   samples strictly above their predecessor
//   last_gt, last_lt, last_eq      relation of latest sample to its predecessor
module four_bit_minmax_tracker #(
   parameter int WIDTH = 4,
   parameter int WINDOW = 4,
   localparam int CW = $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [WIDTH-1:0] out_min,
   output logic [CW-1:0]    out_max_cnt,
   output logic [CW-1:0]    out_min_cnt,
   output logic [CW-1:0]    out_rise_cnt,
   output logic             last_gt,
   output logic             last_lt,
   output logic             last_eq
);
   typedef enum logic {COLLECT, HOLD} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] prev;
   logic accept, first, last;
   assign in_ready = (state == COLLECT);
   assign out_valid = (state == HOLD);
   assign accept = in_valid && in_ready;
   // cnt is cleared at window end, so after a deliver the next accept starts a new window
   assign first = (cnt == '0);
   assign last = (cnt == CW'(WINDOW - 1));
   always_ff @(posedge clk) begin
      if (rst) state <= COLLECT;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      if (state == COLLECT && accept && last) state_n = HOLD;
      else if (state == HOLD && out_ready) state_n = COLLECT;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         prev <= '0;
         out_max <= '0;
         out_min <= '0;
         out_max_cnt <= '0;
         out_min_cnt <= '0;
         out_rise_cnt <= '0;
         last_gt <= 1'b0;
         last_lt <= 1'b0;
         last_eq <= 1'b0;
      end else if (accept) begin
         if (first) begin
            out_max <= in_data;
            out_min <= in_data;
            out_max_cnt <= CW'(1);
            out_min_cnt <= CW'(1);
            out_rise_cnt <= '0;
            last_gt <= 1'b0;
            last_lt <= 1'b0;
            last_eq <= 1'b0;
         end else begin
            if (in_data > out_max) begin
               out_max <= in_data;
               out_max_cnt <= CW'(1);
            end else if (in_data == out_max) out_max_cnt <= out_max_cnt + CW'(1);
            if (in_data < out_min) begin
               out_min <= in_data;
               out_min_cnt <= CW'(1);
            end else if (in_data == out_min) out_min_cnt <= out_min_cnt + CW'(1);
            last_gt <= in_data > prev;
            last_lt <= in_data < prev;
            last_eq <= in_data == prev;
            if (in_data > prev) out_rise_cnt <= out_rise_cnt + CW'(1);
         end
         prev <= in_data;
         cnt <= last ? '0 : cnt + CW'(1);
      end
   end
endmodule

// File: tb/tb_four_bit_minmax_tracker.sv
// tb_four_bit_minmax_tracker: directed plus randomized check of four_bit_minmax_tracker against a window-queue model.
module tb_four_bit_minmax_tracker;
   localparam int WIDTH = 4;
   localparam int WINDOW = 4;
   localparam int CW = $clog2(WINDOW + 1);
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
   logic [WIDTH-1:0] in_data = '0;
   logic in_ready, out_valid, last_gt, last_lt, last_eq;
   logic [WIDTH-1:0] out_max, out_min;
   logic [CW-1:0] out_max_cnt, out_min_cnt, out_rise_cnt;
   int checks = 0, fails = 0;
   int win[$];
   bit hold = 0, fresh = 1;
   four_bit_minmax_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max), .out_min(out_min),
      .out_max_cnt(out_max_cnt), .out_min_cnt(out_min_cnt), .out_rise_cnt(out_rise_cnt),
      .last_gt(last_gt), .last_lt(last_lt), .last_eq(last_eq)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic check_model();
      int mx = 0, mn = 0, mxc = 0, mnc = 0, rc = 0, g = 0, l = 0, e = 0;
      if (win.size() > 0) begin
         mx = win.max()[0];
         mn = win.min()[0];
         foreach (win[i]) begin
            if (win[i] == mx) mxc++;
            if (win[i] == mn) mnc++;
            if (i > 0 && win[i] > win[i-1]) rc++;
         end
         if (win.size() >= 2) begin
            g = int'(win[$] > win[$-1]);
            l = int'(win[$] < win[$-1]);
            e = int'(win[$] == win[$-1]);
         end
      end
      chk("in_ready", 8'(in_ready), 8'(!hold));
      chk("out_valid", 8'(out_valid), 8'(hold));
      chk("out_max", 8'(out_max), 8'(mx));
      chk("out_min", 8'(out_min), 8'(mn));
      chk("max_cnt", 8'(out_max_cnt), 8'(mxc));
      chk("min_cnt", 8'(out_min_cnt), 8'(mnc));
      chk("rise_cnt", 8'(out_rise_cnt), 8'(rc));
      chk("last_gt", 8'(last_gt), 8'(g));
      chk("last_lt", 8'(last_lt), 8'(l));
      chk("last_eq", 8'(last_eq), 8'(e));
   endtask
   task automatic step(input bit v, input int d, input bit ordy, input bit r);
      in_valid = v;
      in_data = WIDTH'(d);
      out_ready = ordy;
      rst = r;
      @(posedge clk);
      if (r) begin
         win.delete();
         hold = 0;
         fresh = 1;
      end else if (v && !hold) begin
         if (fresh) win.delete();
         fresh = 0;
         win.push_back(d);
         if (win.size() == WINDOW) hold = 1;
      end else if (hold && ordy) begin
         hold = 0;
         fresh = 1;
      end
      #1 check_model();
   endtask
   task automatic feed(input int a, input int b, input int c, input int d);
      step(1, a, 0, 0);
      step(1, b, 0, 0);
      step(1, c, 0, 0);
      step(1, d, 0, 0);
   endtask
   initial begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      chk("rst_in_ready", 8'(in_ready), 8'd1);
      chk("rst_out_max", 8'(out_max), 8'd0);
      feed(3, 9, 9, 1);
      chk("mix_max", 8'(out_max), 8'd9);
      chk("mix_max_cnt", 8'(out_max_cnt), 8'd2);
      chk("mix_min", 8'(out_min), 8'd1);
      chk("mix_min_cnt", 8'(out_min_cnt), 8'd1);
      chk("mix_rise", 8'(out_rise_cnt), 8'd1);
      chk("mix_last_lt", 8'(last_lt), 8'd1);
      chk("mix_valid", 8'(out_valid), 8'd1);
      step(0, 0, 1, 0);
      feed(15, 15, 15, 15);
      chk("eq_max", 8'(out_max), 8'd15);
      chk("eq_min_cnt", 8'(out_min_cnt), 8'd4);
      chk("eq_rise", 8'(out_rise_cnt), 8'd0);
      chk("eq_last_eq", 8'(last_eq), 8'd1);
      for (int i = 0; i < 5; i++) step(1, 7, 0, 0);
      chk("bp_in_ready", 8'(in_ready), 8'd0);
      chk("bp_max", 8'(out_max), 8'd15);
      step(1, 7, 1, 0);
      chk("dlv_valid", 8'(out_valid), 8'd0);
      chk("dlv_in_ready", 8'(in_ready), 8'd1);
      feed(0, 1, 2, 3);
      chk("ramp_max", 8'(out_max), 8'd3);
      chk("ramp_min", 8'(out_min), 8'd0);
      chk("ramp_rise", 8'(out_rise_cnt), 8'd3);
      step(0, 0, 1, 0);
      step(1, 5, 0, 0);
      step(0, 0, 0, 0);
      step(1, 2, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 8, 0, 0);
      step(0, 0, 0, 0);
      step(1, 8, 0, 0);
      chk("bub_max", 8'(out_max), 8'd8);
      chk("bub_max_cnt", 8'(out_max_cnt), 8'd2);
      chk("bub_min", 8'(out_min), 8'd2);
      chk("bub_rise", 8'(out_rise_cnt), 8'd1);
      step(0, 0, 1, 0);
      step(1, 9, 0, 0);
      step(1, 1, 0, 0);
      step(1, 6, 0, 1);
      feed(4, 4, 4, 4);
      chk("rmid_max_cnt", 8'(out_max_cnt), 8'd4);
      chk("rmid_valid", 8'(out_valid), 8'd1);
      step(0, 0, 0, 1);
      chk("rhold_valid", 8'(out_valid), 8'd0);
      chk("rhold_max", 8'(out_max), 8'd0);
      for (int i = 0; i < 500; i++)
         step($urandom_range(0, 3) != 0, (i % 3 == 0) ? int'($urandom_range(6, 8)) : int'($urandom_range(0, 15)),
              $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
